hack_screen_scan: RTL and testbench



---
 rtl/hack_screen_scan.sv | 130 +++++++++++++
 tb/tb_hack_screen_scan.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hack_screen_scan.sv
// Purpose: scan the 512x256 Hack framebuffer and emit a 640x480 VGA-timed monochrome stream, image centred.
// Latency: outputs are registered on each pixel tick and describe the (h,v) position held before that tick.
// Backpressure: none; timing advances only on pix_en, RAM data must be valid one clk after fb_addr/fb_rd.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pix_en              pixel tick enable
//   fb_addr, fb_rd      framebuffer read address (row*32 + word) and one-clk read strobe
//   fb_data             RAM read data, registered by the RAM one clk after fb_addr
//   hsync, vsync        active-low syncs
//   de, pixel           visible-area flag and pixel value (1 = set)
//   frame_start         one-tick pulse for position (0,0)
module hack_screen_scan #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned X_OFFSET  = 64,
    parameter int unsigned Y_OFFSET  = 112
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic [12:0] fb_addr,
    output logic        fb_rd,
    input  logic [15:0] fb_data,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        pixel,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [14:0]   shreg_q;

    // 32-bit views of the counters so window arithmetic never truncates
    logic [31:0] h_w, v_w;
    logic [31:0] fx;    // position relative to the fetch grid (X_OFFSET-2)
    logic [31:0] sx;    // image column
    logic [31:0] row;   // image row
    logic        in_y, in_x, fetch_hit, hs_lo, vs_lo;

    assign h_w = 32'(h_q);
    assign v_w = 32'(v_q);

    // Subtractions wrap to huge values left/above the window, so one
    // unsigned "< size" compare covers both window edges.
    assign fx  = h_w + 32'd2 - X_OFFSET;
    assign sx  = h_w - X_OFFSET;
    assign row = v_w - Y_OFFSET;

    assign in_y      = row < 32'd256;
    assign in_x      = sx < 32'd512;
    assign fetch_hit = in_y && (fx < 32'd512) && (fx[3:0] == 4'd0);

    assign hs_lo = (h_w >= H_VISIBLE + H_FRONT) && (h_w < H_VISIBLE + H_FRONT + H_SYNC);
    assign vs_lo = (v_w >= V_VISIBLE + V_FRONT) && (v_w < V_VISIBLE + V_FRONT + V_SYNC);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            if (v_q == VW'(V_TOTAL - 1)) begin
                v_d = '0;
            end else begin
                v_d = v_q + VW'(1);
            end
        end else begin
            h_d = h_q + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q         <= '0;
            v_q         <= '0;
            shreg_q     <= '0;
            fb_addr     <= '0;
            fb_rd       <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            pixel       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // strobe is one clk wide regardless of pix_en
            fb_rd <= 1'b0;
            if (pix_en) begin
                h_q         <= h_d;
                v_q         <= v_d;
                de          <= (h_w < H_VISIBLE) && (v_w < V_VISIBLE);
                hsync       <= !hs_lo;
                vsync       <= !vs_lo;
                frame_start <= (h_q == '0) && (v_q == '0);

                // word k is fetched two ticks ahead of its first pixel
                if (fetch_hit) begin
                    fb_addr <= {row[7:0], fx[8:4]};
                    fb_rd   <= 1'b1;
                end

                if (in_y && in_x) begin
                    if (sx[3:0] == 4'd0) begin
                        // LSB is the leftmost pixel of the word
                        pixel   <= fb_data[0];
                        shreg_q <= fb_data[15:1];
                    end else begin
                        pixel   <= shreg_q[0];
                        shreg_q <= {1'b0, shreg_q[14:1]};
                    end
                end else begin
                    pixel <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hack_screen_scan.sv
// Purpose: randomized self-checking bench for hack_screen_scan against a position-based reference model.
// Latency: model predicts the outputs from the tick count since reset; compared every clk on the falling edge.
// Backpressure: pix_en is driven continuous, toggling and random to exercise the hold behaviour.
module tb_hack_screen_scan;

    // Shrunk timing so whole frames fit in a short run; image stays 512x256.
    localparam int unsigned HV = 530, HF = 6, HS = 10, HB = 4;
    localparam int unsigned VV = 12, VF = 2, VS = 2, VB = 2;
    localparam int unsigned XO = 8, YO = 3;
    localparam int HT    = 550;
    localparam int VT    = 18;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b1;
    logic [12:0] fb_addr;
    logic        fb_rd;
    logic [15:0] fb_data = 16'h0000;
    logic        hsync, vsync, de, pixel, frame_start;

    logic [15:0] mem [0:8191];

    int checks = 0;
    int errors = 0;

    hack_screen_scan #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .X_OFFSET(XO), .Y_OFFSET(YO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
        .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel),
        .frame_start(frame_start)
    );

    initial forever #5 clk = ~clk;

    // Read-enabled synchronous RAM: data holds between reads.
    always @(posedge clk) if (fb_rd) fb_data <= mem[fb_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          was_tick, was_rst;
    int          ntick;
    logic        e_hs, e_vs, e_de, e_pix, e_fs, e_rd;
    logic [12:0] e_addr;

    task automatic model(input int pos);
        int h, v, x, y, fx;
        logic [15:0] w;
        h = pos % HT;
        v = (pos / HT) % VT;
        e_de = (h < HV) && (v < VV);
        e_hs = !((h >= HV + HF) && (h < HV + HF + HS));
        e_vs = !((v >= VV + VF) && (v < VV + VF + VS));
        e_fs = (h == 0) && (v == 0);
        y = v - YO;
        x = h - XO;
        e_pix = 1'b0;
        if (y >= 0 && y < 256 && x >= 0 && x < 512) begin
            w = mem[y * 32 + x / 16];
            e_pix = w[x % 16];
        end
        fx = h + 2 - XO;
        e_rd = 1'b0;
        if (y >= 0 && y < 256 && fx >= 0 && fx < 512 && fx % 16 == 0) begin
            e_rd   = 1'b1;
            e_addr = 13'(y * 32 + fx / 16);
        end
    endtask

    initial forever begin
        @(posedge clk);
        was_tick = pix_en;
        was_rst  = !rst_n;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n || was_rst) begin
            ntick = 0;
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_pix = 1'b0;
            e_fs = 1'b0; e_rd = 1'b0; e_addr = '0;
        end else if (was_tick) begin
            model(ntick);
            ntick++;
        end else begin
            e_rd = 1'b0;
        end
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("de", 32'(de), 32'(e_de));
        chk("pixel", 32'(pixel), 32'(e_pix));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("fb_rd", 32'(fb_rd), 32'(e_rd));
        chk("fb_addr", 32'(fb_addr), 32'(e_addr));
    end

    // ---------------- stimulus ----------------
    task automatic restart();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // Phase 1: continuous ticks, two frames, literal pins on the model.
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        mem[0]   = 16'h0001;
        mem[1]   = 16'h8000;
        mem[287] = 16'hFFFF;              // row 8 (v=11), word 31
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int p = 0; p < 2 * FRAME + 300; p++) begin
            @(posedge clk);
            #1;
            case (p)
                0:    begin chk("lit_fs0", 32'(frame_start), 1); chk("lit_de0", 32'(de), 1); end
                1:    chk("lit_fs1", 32'(frame_start), 0);
                529:  chk("lit_de_h529", 32'(de), 1);
                530:  chk("lit_de_h530", 32'(de), 0);
                535:  chk("lit_hs535", 32'(hsync), 1);
                536:  chk("lit_hs536", 32'(hsync), 0);
                545:  chk("lit_hs545", 32'(hsync), 0);
                546:  chk("lit_hs546", 32'(hsync), 1);
                1656: begin chk("lit_rd_first", 32'(fb_rd), 1); chk("lit_addr_first", 32'(fb_addr), 0); end
                1657: chk("lit_rd_drop", 32'(fb_rd), 0);
                1658: chk("lit_pix_8_3", 32'(pixel), 1);
                1659: chk("lit_pix_9_3", 32'(pixel), 0);
                1672: begin chk("lit_rd_w1", 32'(fb_rd), 1); chk("lit_addr_w1", 32'(fb_addr), 1); end
                1688: chk("lit_pix_38_3", 32'(pixel), 0);
                1689: chk("lit_pix_39_3", 32'(pixel), 1);
                6552: begin chk("lit_rd_last", 32'(fb_rd), 1); chk("lit_addr_last", 32'(fb_addr), 287); end
                6554: chk("lit_pix_504_11", 32'(pixel), 1);
                6569: chk("lit_pix_519_11", 32'(pixel), 1);
                6570: begin chk("lit_pix_520_11", 32'(pixel), 0); chk("lit_de_520_11", 32'(de), 1); end
                6600: chk("lit_de_v12", 32'(de), 0);
                7699: chk("lit_vs_v13", 32'(vsync), 1);
                7700: chk("lit_vs_v14", 32'(vsync), 0);
                8799: chk("lit_vs_v15", 32'(vsync), 0);
                8800: chk("lit_vs_v16", 32'(vsync), 1);
                9900: chk("lit_fs_frame2", 32'(frame_start), 1);
                default: ;
            endcase
        end

        // Mid-line asynchronous reset: outputs clear without a clock edge.
        rst_n = 1'b0;
        #1;
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_de", 32'(de), 0);
        chk("rst_pixel", 32'(pixel), 0);
        chk("rst_fb_rd", 32'(fb_rd), 0);
        chk("rst_fs", 32'(frame_start), 0);

        // Phase 2: all-ones framebuffer, border must stay blank.
        for (int i = 0; i < 8192; i++) mem[i] = 16'hFFFF;
        restart();
        repeat (FRAME) @(posedge clk);

        // Phase 3: pix_en toggling 1,0 with 0xAAAA everywhere.
        rst_n = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 16'hAAAA;
        restart();
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(posedge clk);
            #1 pix_en = ~pix_en;
        end

        // Phase 4: random data, random pix_en, with a reset in the middle.
        rst_n  = 1'b0;
        pix_en = 1'b1;
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        restart();
        for (int c = 0; c < 8000; c++) begin
            @(posedge clk);
            #1;
            pix_en = ($urandom_range(3) != 0);
            if (c == 4000) rst_n = 1'b0;
            if (c == 4002) rst_n = 1'b1;
        end

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
